// File: rtl/pcm_pkg.sv
// Shared state encoding, default widths and device opcodes for the PCM/flash bus controller.
package pcm_pkg;

    localparam int PCM_ADDR_W = 23;
    localparam int PCM_DATA_W = 16;

    localparam logic [15:0] CMD_READ_ID    = 16'h0090;
    localparam logic [15:0] CMD_READ_ARRAY = 16'h00FF;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETUP,
        ACCESS,
        RECOV
    } pcm_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pcm_arb2.sv
// Two-requester arbiter producing a one-hot winner.
// With PCM_BUS_CTRL_RR_EN defined the port not granted last wins a tie; otherwise port 0 always wins.
module pcm_arb2 (
    input  logic [1:0] req,
`ifdef PCM_BUS_CTRL_RR_EN
    input  logic       last_port,
`endif
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        if (req[0] && !req[1]) begin
            win = 2'b01;
        end else if (req[1] && !req[0]) begin
            win = 2'b10;
        end else if (req[0] && req[1]) begin
`ifdef PCM_BUS_CTRL_RR_EN
            win = last_port ? 2'b01 : 2'b10;
`else
            win = 2'b01;
`endif
        end
    end

endmodule

// File: rtl/pcm_bus_ctrl.sv
// Sequencer and two-port arbiter for the parallel PCM/flash bus: INIT, then single
// read/write cycles with SETUP/ACCESS/RECOV timing. PCM_BUS_CTRL_RR_EN enables round-robin.
module pcm_bus_ctrl
    import pcm_pkg::*;
#(
    parameter int ADDR_W    = PCM_ADDR_W,
    parameter int DATA_W    = PCM_DATA_W,
    parameter int RESET_CYC = 15,
    parameter int WAIT_CYC  = 12,
    parameter int RECOV_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        wr,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] pcm_addr,
    output logic [DATA_W-1:0] pcm_dq_o,
    output logic              pcm_dq_oe,
    input  logic [DATA_W-1:0] pcm_dq_i,
    output logic              pcm_rst_n,
    output logic              pcm_ce_n,
    output logic              pcm_oe_n,
    output logic              pcm_we_n
);

    // The counter is loaded with N-1 and the phase ends when it reads zero.
    localparam int CNT_MAX = max3(RESET_CYC, WAIT_CYC, RECOV_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] RECOV_LOAD = CNT_W'(RECOV_CYC - 1);

    pcm_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [1:0]        gnt_reg, gnt_next;
    logic [1:0]        done_reg, done_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] dq_o_reg, dq_o_next;
    logic              dq_oe_reg, dq_oe_next;
    logic              rst_n_reg, rst_n_next;
    logic              ce_n_reg, ce_n_next;
    logic              oe_n_reg, oe_n_next;
    logic              we_n_reg, we_n_next;
    logic              wr_lat_reg, wr_lat_next;

    logic [1:0]        win;
    logic              sel;
    logic              wr_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

`ifdef PCM_BUS_CTRL_RR_EN
    logic last_port_reg, last_port_next;

    pcm_arb2 u_arb (
        .req       (req),
        .last_port (last_port_reg),
        .win       (win)
    );
`else
    pcm_arb2 u_arb (
        .req (req),
        .win (win)
    );
`endif

    assign sel       = win[1];
    assign wr_sel    = wr[sel];
    assign addr_sel  = sel ? addr1 : addr0;
    assign wdata_sel = sel ? wdata1 : wdata0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= INIT;
            cnt_reg    <= RESET_LOAD;
            gnt_reg    <= '0;
            done_reg   <= '0;
            rdata_reg  <= '0;
            addr_reg   <= '0;
            dq_o_reg   <= '0;
            dq_oe_reg  <= 1'b0;
            rst_n_reg  <= 1'b0;
            ce_n_reg   <= 1'b1;
            oe_n_reg   <= 1'b1;
            we_n_reg   <= 1'b1;
            wr_lat_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            gnt_reg    <= gnt_next;
            done_reg   <= done_next;
            rdata_reg  <= rdata_next;
            addr_reg   <= addr_next;
            dq_o_reg   <= dq_o_next;
            dq_oe_reg  <= dq_oe_next;
            rst_n_reg  <= rst_n_next;
            ce_n_reg   <= ce_n_next;
            oe_n_reg   <= oe_n_next;
            we_n_reg   <= we_n_next;
            wr_lat_reg <= wr_lat_next;
        end
    end

`ifdef PCM_BUS_CTRL_RR_EN
    // Reset to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_port_reg <= 1'b1;
        end else begin
            last_port_reg <= last_port_next;
        end
    end
`endif

    // Every output is computed here for the next cycle and registered above.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        gnt_next    = gnt_reg;
        done_next   = 2'b00;
        rdata_next  = rdata_reg;
        addr_next   = addr_reg;
        dq_o_next   = dq_o_reg;
        dq_oe_next  = dq_oe_reg;
        rst_n_next  = rst_n_reg;
        ce_n_next   = ce_n_reg;
        oe_n_next   = oe_n_reg;
        we_n_next   = we_n_reg;
        wr_lat_next = wr_lat_reg;
`ifdef PCM_BUS_CTRL_RR_EN
        last_port_next = last_port_reg;
`endif

        case (state_reg)
            INIT: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                    rst_n_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            IDLE: begin
                if (|req) begin
                    state_next  = SETUP;
                    gnt_next    = win;
                    wr_lat_next = wr_sel;
                    addr_next   = addr_sel;
                    ce_n_next   = 1'b0;
                    dq_oe_next  = wr_sel;
                    if (wr_sel) begin
                        dq_o_next = wdata_sel;
                    end
`ifdef PCM_BUS_CTRL_RR_EN
                    last_port_next = sel;
`endif
                end
            end

            SETUP: begin
                state_next = ACCESS;
                cnt_next   = WAIT_LOAD;
                oe_n_next  = wr_lat_reg;
                we_n_next  = !wr_lat_reg;
            end

            ACCESS: begin
                if (cnt_reg == '0) begin
                    state_next = RECOV;
                    cnt_next   = RECOV_LOAD;
                    ce_n_next  = 1'b1;
                    oe_n_next  = 1'b1;
                    we_n_next  = 1'b1;
                    done_next  = gnt_reg;
                    if (!wr_lat_reg) begin
                        rdata_next = pcm_dq_i;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            RECOV: begin
                // Write data is held on the pad only through the first recovery cycle.
                dq_oe_next = 1'b0;
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                    gnt_next   = 2'b00;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign gnt       = gnt_reg;
    assign done      = done_reg;
    assign rdata     = rdata_reg;
    assign pcm_addr  = addr_reg;
    assign pcm_dq_o  = dq_o_reg;
    assign pcm_dq_oe = dq_oe_reg;
    assign pcm_rst_n = rst_n_reg;
    assign pcm_ce_n  = ce_n_reg;
    assign pcm_oe_n  = oe_n_reg;
    assign pcm_we_n  = we_n_reg;

endmodule
